// File: rtl/screen_xform_arb_pkg.sv
// screen_xform_arb_pkg: shared widths and response entry type for the
// screen transform arbiter and the raster stage.
package screen_xform_arb_pkg;

    localparam int CIN_W    = 8;
    localparam int COUT_W   = 16;
    localparam int ID_MAX_W = 3;

    function automatic int id_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [COUT_W-1:0]   x;
        logic [COUT_W-1:0]   y;
    } xf_entry_t;

endpackage

// File: rtl/screen_xform_fifo.sv
// screen_xform_fifo: synchronous FIFO with occupancy count; reads as zero
// while empty so downstream outputs sit at their reset values.
module screen_xform_fifo
#(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push & (cnt_q != CW'(DEPTH));
        do_pop  = pop & (cnt_q != '0);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = empty ? '0 : mem_q[rd_q];

endmodule

// File: rtl/screen_xform_arb.sv
// screen_xform_arb: round-robin arbiter sharing one screen transform unit.
// Optional result clipping is enabled by SCREEN_XFORM_ARB_CLIP_EN.
module screen_xform_arb
    import screen_xform_arb_pkg::*;
#(
    parameter int  N_REQ  = 4,
    parameter int  XF_LAT = 2,
    parameter int  DEPTH  = 4,
    parameter int  WIDTH  = 320,
    parameter int  HEIGHT = 200,
    localparam int IDW    = id_width(N_REQ)
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [CIN_W*N_REQ-1:0] req_x,
    input  logic [CIN_W*N_REQ-1:0] req_y,
    output logic                   xf_enb,
    output logic [CIN_W-1:0]       xf_x,
    output logic [CIN_W-1:0]       xf_y,
    input  logic [COUT_W-1:0]      xf_xout,
    input  logic [COUT_W-1:0]      xf_yout,
    input  logic                   xf_valid,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [COUT_W-1:0]      rsp_x,
    output logic [COUT_W-1:0]      rsp_y,
`ifdef SCREEN_XFORM_ARB_CLIP_EN
    output logic [15:0]            clip_cnt,
`endif
    output logic                   err_orphan
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int UW = CW + 1;
    localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("N_REQ must be 2..8");
    end
    if (XF_LAT < 1 || XF_LAT > 8) begin : g_bad_lat
        $error("XF_LAT must be 1..8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2, >= 2");
    end
    if (WIDTH < 1 || WIDTH > 65535 || HEIGHT < 1 || HEIGHT > 65535) begin : g_bad_scr
        $error("WIDTH/HEIGHT out of range");
    end

    logic [CIN_W-1:0] rx [N_REQ];
    logic [CIN_W-1:0] ry [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign rx[g] = req_x[CIN_W*g +: CIN_W];
        assign ry[g] = req_y[CIN_W*g +: CIN_W];
    end

    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   gidx, idx;
    logic             found, accept, credit_ok;
    logic             xf_enb_q;
    logic [CIN_W-1:0] xf_x_q, xf_x_d;
    logic [CIN_W-1:0] xf_y_q, xf_y_d;
    logic             orphan_q, orphan_d;
    logic [CW-1:0]    tag_cnt, rsp_cnt;
    logic             tag_empty, rsp_empty;
    logic [IDW-1:0]   tag_dout;
    xf_entry_t        rsp_din, rsp_ent;
    logic             res_ok, clip_hit, rsp_push, rsp_pop;
    logic [UW-1:0]    used;

    // A pop this cycle already frees its slot for a same-cycle acceptance.
    always_comb begin
        rsp_pop   = ~rsp_empty & rsp_ready;
        used      = UW'(tag_cnt) + UW'(rsp_cnt) - UW'(rsp_pop);
        credit_ok = used < UW'(DEPTH);
    end

    always_comb begin
        idx   = last_q;
        gidx  = last_q;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (idx == LAST) ? '0 : idx + 1'b1;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        accept    = found & credit_ok & ARESETN;
        req_ready = '0;
        if (accept) req_ready[gidx] = 1'b1;
    end

    always_comb begin
        last_d   = accept ? gidx : last_q;
        xf_x_d   = accept ? rx[gidx] : xf_x_q;
        xf_y_d   = accept ? ry[gidx] : xf_y_q;
        res_ok   = xf_valid & ~tag_empty;
        orphan_d = orphan_q | (xf_valid & tag_empty);
        rsp_push = res_ok & ~clip_hit;
        rsp_din.id = ID_MAX_W'(tag_dout);
        rsp_din.x  = xf_xout;
        rsp_din.y  = xf_yout;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            last_q   <= LAST;
            xf_enb_q <= 1'b0;
            xf_x_q   <= '0;
            xf_y_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            xf_enb_q <= accept;
            xf_x_q   <= xf_x_d;
            xf_y_q   <= xf_y_d;
            orphan_q <= orphan_d;
        end
    end

`ifdef SCREEN_XFORM_ARB_CLIP_EN
    logic [15:0] clip_q, clip_d;

    assign clip_hit = res_ok & ((xf_xout >= COUT_W'(WIDTH)) |
                                (xf_yout >= COUT_W'(HEIGHT)));
    assign clip_d   = (clip_hit && clip_q != '1) ? clip_q + 1'b1 : clip_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) clip_q <= '0;
        else          clip_q <= clip_d;
    end

    assign clip_cnt = clip_q;
`else
    assign clip_hit = 1'b0;
`endif

    // Tag queue occupancy doubles as the in-flight transform count.
    screen_xform_fifo #(.W(IDW), .DEPTH(DEPTH)) u_tag_q (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (accept),
        .din   (gidx),
        .pop   (res_ok),
        .dout  (tag_dout),
        .count (tag_cnt),
        .empty (tag_empty)
    );

    screen_xform_fifo #(.W($bits(xf_entry_t)), .DEPTH(DEPTH)) u_rsp_q (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (rsp_push),
        .din   (rsp_din),
        .pop   (rsp_pop),
        .dout  (rsp_ent),
        .count (rsp_cnt),
        .empty (rsp_empty)
    );

    assign xf_enb     = xf_enb_q;
    assign xf_x       = xf_x_q;
    assign xf_y       = xf_y_q;
    assign rsp_valid  = ~rsp_empty;
    assign rsp_id     = IDW'(rsp_ent.id);
    assign rsp_x      = rsp_ent.x;
    assign rsp_y      = rsp_ent.y;
    assign err_orphan = orphan_q;

endmodule

// File: tb/tb_screen_xform_arb.sv
// tb_screen_xform_arb: randomized and directed checks of screen_xform_arb
// against a queue-based reference model and a model transform unit.
module tb_screen_xform_arb;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int D   = 4;
    localparam int W   = 320;
    localparam int H   = 200;

    logic           ACLK = 1'b0;
    logic           ARESETN = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_x = '0;
    logic [8*N-1:0] req_y = '0;
    logic           xf_enb;
    logic [7:0]     xf_x, xf_y;
    logic [15:0]    xf_xout, xf_yout;
    logic           xf_valid;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [15:0]    rsp_x, rsp_y;
    logic           err_orphan;
`ifdef SCREEN_XFORM_ARB_CLIP_EN
    logic [15:0]    clip_cnt;
`endif

    logic           inj = 1'b0;
    logic           clip_force = 1'b0;
    int             total = 0;
    int             bad = 0;

    typedef struct {
        int          id;
        logic [15:0] x;
        logic [15:0] y;
        int          avail;
    } exp_t;

    exp_t q[$];

    screen_xform_arb #(
        .N_REQ(N), .XF_LAT(LAT), .DEPTH(D), .WIDTH(W), .HEIGHT(H)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .xf_enb     (xf_enb),
        .xf_x       (xf_x),
        .xf_y       (xf_y),
        .xf_xout    (xf_xout),
        .xf_yout    (xf_yout),
        .xf_valid   (xf_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_x      (rsp_x),
        .rsp_y      (rsp_y),
`ifdef SCREEN_XFORM_ARB_CLIP_EN
        .clip_cnt   (clip_cnt),
`endif
        .err_orphan (err_orphan)
    );

    always #5 ACLK = ~ACLK;

    // Normalized [-128,127] mapped linearly onto [0,span).
    function automatic logic [15:0] fx(input logic [7:0] v, input int span);
        int s;
        s = int'($signed(v)) + 128;
        return 16'((s * span) / 256);
    endfunction

    function automatic int pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    logic        pv [LAT];
    logic [15:0] px [LAT];
    logic [15:0] py [LAT];

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            pv[0] <= xf_enb;
            px[0] <= clip_force ? 16'(W) : fx(xf_x, W);
            py[0] <= fx(xf_y, H);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    assign xf_valid = pv[LAT-1] | inj;
    assign xf_xout  = px[LAT-1];
    assign xf_yout  = py[LAT-1];

    task automatic do_reset();
        ARESETN    = 1'b0;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        inj        = 1'b0;
        clip_force = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic test_reset();
        ARESETN   = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        @(negedge ACLK);
        #1;
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready);
        end
        total++;
        if (xf_enb !== 1'b0 || xf_x !== 8'h0 || xf_y !== 8'h0) begin
            bad++; $display("FAIL reset_xf got=%b/%h/%h exp=0", xf_enb, xf_x, xf_y);
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_x !== 16'h0 || rsp_y !== 16'h0) begin
            bad++; $display("FAIL reset_rsp got=%b/%0d/%h/%h exp=0", rsp_valid, rsp_id, rsp_x, rsp_y);
        end
        total++;
        if (err_orphan !== 1'b0) begin
            bad++; $display("FAIL reset_orphan got=%b exp=0", err_orphan);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic test_single();
        logic [15:0] ex, ey;
        do_reset();
        rsp_ready = 1'b1;
        req_x = '0;
        req_y = '0;
        req_x[23:16] = 8'h20;
        req_y[23:16] = 8'hE0;
        ex = fx(8'h20, W);
        ey = fx(8'hE0, H);
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        @(negedge ACLK);
        req_valid = '0;
        #1;
        total++;
        if (xf_enb !== 1'b1 || xf_x !== 8'h20 || xf_y !== 8'hE0) begin
            bad++; $display("FAIL single_issue got=%b/%h/%h exp=1/20/e0", xf_enb, xf_x, xf_y);
        end
        @(negedge ACLK);
        #1;
        total++;
        if (xf_enb !== 1'b0) begin
            bad++; $display("FAIL single_enb_pulse got=%b exp=0", xf_enb);
        end
        @(negedge ACLK);
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_early got=%b exp=0", rsp_valid);
        end
        @(negedge ACLK);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_x !== ex || rsp_y !== ey) begin
            bad++;
            $display("FAIL single_rsp got=%b/%0d/%0d/%0d exp=1/2/%0d/%0d",
                     rsp_valid, rsp_id, rsp_x, rsp_y, ex, ey);
        end
        @(negedge ACLK);
    endtask

    task automatic test_fairness();
        exp_t e;
        int   last, g, n;
        do_reset();
        q.delete();
        last = N - 1;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 40; k++) begin
            if (k == 8) req_valid = '0;
            req_x = (8*N)'($urandom);
            req_y = (8*N)'($urandom);
            #1;
            if (k < 8) begin
                g = pick(last, req_valid);
                total++;
                if (req_ready !== N'(1 << (k % N)) || g != k % N) begin
                    bad++; $display("FAIL fair_grant%0d got=%b exp=%0d", k, req_ready, k % N);
                end
                e.id = g;
                e.x = fx(req_x[8*g +: 8], W);
                e.y = fx(req_y[8*g +: 8], H);
                e.avail = 0;
                q.push_back(e);
                last = g;
            end
            if (rsp_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL fair_extra got=%0d exp=none", rsp_id);
                end else begin
                    if (rsp_id !== 2'(q[0].id) || rsp_x !== q[0].x || rsp_y !== q[0].y) begin
                        bad++;
                        $display("FAIL fair_rsp got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                 rsp_id, rsp_x, rsp_y, q[0].id, q[0].x, q[0].y);
                    end
                    void'(q.pop_front());
                end
            end
            @(negedge ACLK);
            if (k >= 8 && q.size() == 0) break;
        end
        n = q.size();
        total++;
        if (n != 0) begin
            bad++; $display("FAIL fair_drain got=%0d left exp=0", n);
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (|req_ready) cnt++;
            @(negedge ACLK);
        end
        total++;
        if (cnt != D) begin
            bad++; $display("FAIL bp_accepts got=%0d exp=%0d", cnt, D);
        end
        #1;
        total++;
        if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            bad++; $display("FAIL bp_stall got=%b/%b/%0d exp=0000/1/0", req_ready, rsp_valid, rsp_id);
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL bp_pop_accept got=%b exp=0001", req_ready);
        end
        @(negedge ACLK);
        rsp_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== '0 || rsp_id !== 2'd1) begin
            bad++; $display("FAIL bp_after got=%b/%0d exp=0000/1", req_ready, rsp_id);
        end
        @(negedge ACLK);
    endtask

    task automatic test_orphan();
        bit seen;
        do_reset();
        inj = 1'b1;
        @(negedge ACLK);
        inj = 1'b0;
        #1;
        total++;
        if (err_orphan !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL orphan_set got=%b/%b exp=1/0", err_orphan, rsp_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (err_orphan !== 1'b1 || seen) begin
            bad++; $display("FAIL orphan_sticky got=%b/%b exp=1/0", err_orphan, seen);
        end
        ARESETN = 1'b0;
        #1;
        total++;
        if (err_orphan !== 1'b0) begin
            bad++; $display("FAIL orphan_clear got=%b exp=0", err_orphan);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        repeat (2) @(negedge ACLK);
        req_valid = '0;
        repeat (4) @(negedge ACLK);
        req_valid = 4'b1100;
        repeat (2) @(negedge ACLK);
        req_valid = '1;
        #1;
        total++;
        if (rsp_valid !== 1'b1 || xf_enb !== 1'b1) begin
            bad++; $display("FAIL mid_busy got=%b/%b exp=1/1", rsp_valid, xf_enb);
        end
        ARESETN = 1'b0;
        #1;
        total++;
        if (req_ready !== '0 || xf_enb !== 1'b0 || xf_x !== 8'h0 || xf_y !== 8'h0 ||
            rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_x !== 16'h0 ||
            rsp_y !== 16'h0 || err_orphan !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%b/%h/%h/%b/%0d/%h/%h/%b exp=all0",
                     req_ready, xf_enb, xf_x, xf_y, rsp_valid, rsp_id, rsp_x, rsp_y, err_orphan);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL mid_first got=%b exp=0001", req_ready);
        end
        @(negedge ACLK);
        req_valid = '0;
        repeat (8) @(negedge ACLK);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || err_orphan !== 1'b0) begin
            bad++; $display("FAIL mid_after got=%b/%0d/%b exp=1/0/0", rsp_valid, rsp_id, err_orphan);
        end
    endtask

    task automatic test_random();
        exp_t         e;
        int           g, last, cyc, n;
        logic         rr, ev, pop, cred;
        logic [N-1:0] rv, er;
        do_reset();
        q.delete();
        last = N - 1;
        cyc = 0;
        for (int i = 0; i < 460; i++) begin
            if (i < 400) begin
                rv = N'($urandom);
                rr = ($urandom_range(0, 3) != 0);
            end else begin
                rv = '0;
                rr = 1'b1;
            end
            req_valid = rv;
            rsp_ready = rr;
            req_x = (8*N)'($urandom);
            req_y = (8*N)'($urandom);
            #1;
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            pop = ev && rr;
            cred = (q.size() - int'(pop)) < D;
            g = cred ? pick(last, rv) : -1;
            er = (g >= 0) ? N'(1 << g) : '0;
            total++;
            if (req_ready !== er) begin
                bad++; $display("FAIL rand_grant c%0d got=%b exp=%b", cyc, req_ready, er);
            end
            total++;
            if (rsp_valid !== ev) begin
                bad++; $display("FAIL rand_valid c%0d got=%b exp=%b", cyc, rsp_valid, ev);
            end
            if (pop) begin
                total++;
                if (rsp_id !== 2'(q[0].id) || rsp_x !== q[0].x || rsp_y !== q[0].y) begin
                    bad++;
                    $display("FAIL rand_rsp c%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                             cyc, rsp_id, rsp_x, rsp_y, q[0].id, q[0].x, q[0].y);
                end
                void'(q.pop_front());
            end
            if (g >= 0) begin
                e.id = g;
                e.x = fx(req_x[8*g +: 8], W);
                e.y = fx(req_y[8*g +: 8], H);
                e.avail = cyc + LAT + 2;
                q.push_back(e);
                last = g;
            end
            cyc++;
            @(negedge ACLK);
        end
        n = q.size();
        total++;
        if (n != 0) begin
            bad++; $display("FAIL rand_drain got=%0d left exp=0", n);
        end
    endtask

`ifdef SCREEN_XFORM_ARB_CLIP_EN
    task automatic test_clip();
        bit          seen;
        int          cnt;
        logic [15:0] ex;
        do_reset();
        req_x = (8*N)'($urandom);
        req_y = (8*N)'($urandom);
        ex = fx(req_x[23:16], W);
        clip_force = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        @(negedge ACLK);
        req_valid = '0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge ACLK);
        end
        total++;
        if (seen || clip_cnt !== 16'd1) begin
            bad++; $display("FAIL clip_drop got=%b/%0d exp=0/1", seen, clip_cnt);
        end
        clip_force = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (|req_ready) cnt++;
            @(negedge ACLK);
        end
        req_valid = '0;
        total++;
        if (cnt != D) begin
            bad++; $display("FAIL clip_credit got=%0d exp=%0d", cnt, D);
        end
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_x !== ex || clip_cnt !== 16'd1) begin
            bad++;
            $display("FAIL clip_next got=%b/%0d/%0d/%0d exp=1/2/%0d/1",
                     rsp_valid, rsp_id, rsp_x, clip_cnt, ex);
        end
        @(negedge ACLK);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_orphan();
        test_reset_mid();
        test_random();
`ifdef SCREEN_XFORM_ARB_CLIP_EN
        test_clip();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
